// File: rtl/pwr_ctrl_pkg.sv
// Shared power-control types: switch sequencer state encoding and small helpers.
package pwr_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RAMP_UP = 2'd1,
        ON      = 2'd2,
        RAMP_DN = 2'd3
    } psw_state_t;

    function automatic logic psw_is_ramp(input psw_state_t state);
        return (state == RAMP_UP) || (state == RAMP_DN);
    endfunction

endpackage

// File: rtl/psw_step_timer.sv
// Per-step settle counter for the power-switch sequencer.
// With PSW_TIMEOUT_EN defined it also carries the sticky per-step acknowledge watchdog.
module psw_step_timer
    import pwr_ctrl_pkg::*;
#(
    parameter int DLY_W  = 8,
    parameter int TO_CYC = 1023
) (
    input  logic             i_aon_clk,
    input  logic             i_soc_pwr_on_rst,
    input  logic             reload,
    input  logic [DLY_W-1:0] reload_val,
    input  logic             stall,
    output logic             cnt_zero,
    output logic             psw_err
);

    logic [DLY_W-1:0] cnt_r;

    assign cnt_zero = (cnt_r == {DLY_W{1'b0}});

    // Settle down-counter: reload at each step start, otherwise run down to zero and hold
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            cnt_r <= {DLY_W{1'b0}};
        end else if (reload) begin
            cnt_r <= reload_val;
        end else if (!cnt_zero) begin
            cnt_r <= cnt_r - DLY_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef PSW_TIMEOUT_EN
    localparam int WD_W = $clog2(TO_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            psw_err_r;

    // Watchdog: counts stalled cycles of the current step; the error flag stays set until reset
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            wd_cnt_r  <= {WD_W{1'b0}};
            psw_err_r <= 1'b0;
        end else begin
            if (reload) begin
                wd_cnt_r <= {WD_W{1'b0}};
            end else if (stall && (wd_cnt_r != WD_LAST)) begin
                wd_cnt_r <= wd_cnt_r + WD_W'(1);
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
            if (stall && !reload && (wd_cnt_r == WD_LAST)) begin
                psw_err_r <= 1'b1;
            end else begin
                psw_err_r <= psw_err_r;
            end
        end
    end

    assign psw_err = psw_err_r;
`else
    logic stall_unused_s;

    assign stall_unused_s = stall ^ TO_CYC[0];
    assign psw_err        = 1'b0;
`endif

endmodule

// File: rtl/pwr_switch_seq.sv
// Staggered power-switch segment sequencer: thermometer enable ramp up/down with reversal support.
// Optional watchdog error output enabled by defining PSW_TIMEOUT_EN.
module pwr_switch_seq
    import pwr_ctrl_pkg::*;
#(
    parameter int N_SEG  = 4,
    parameter int DLY_W  = 8,
    parameter int TO_CYC = 1023
) (
    input  logic             i_aon_clk,
    input  logic             i_soc_pwr_on_rst,
    input  logic             i_pwr_on_req,
    input  logic [DLY_W-1:0] i_seg_dly,
    input  logic [N_SEG-1:0] i_seg_ack,
    output logic [N_SEG-1:0] o_seg_en,
    output logic             o_pwr_on_ack,
    output logic             o_busy,
    output logic             o_psw_err
);

    localparam int IDX_W = $clog2(N_SEG);
    localparam logic [IDX_W-1:0] IDX_FIRST = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_SEG - 1);

    psw_state_t       state_r;
    logic [IDX_W-1:0] idx_r;
    logic [N_SEG-1:0] seg_en_r;
    logic             pwr_on_ack_r;
    logic             busy_r;

    logic [IDX_W-1:0] idx_inc_s;
    logic [IDX_W-1:0] idx_dec_s;
    logic             cnt_zero_s;
    logic             ack_sel_s;
    logic             up_done_s;
    logic             dn_done_s;
    logic             reload_s;
    logic             stall_s;
    logic             psw_err_s;

    assign idx_inc_s = idx_r + IDX_W'(1);
    assign idx_dec_s = idx_r - IDX_W'(1);
    assign ack_sel_s = i_seg_ack[idx_r];
    assign up_done_s = cnt_zero_s & ack_sel_s;
    assign dn_done_s = cnt_zero_s & ~ack_sel_s;

    // Reload the settle counter whenever a new step starts; flag a stall when settled but unacknowledged
    always_comb begin
        reload_s = 1'b0;
        stall_s  = 1'b0;
        case (state_r)
            OFF: begin
                reload_s = i_pwr_on_req;
            end
            RAMP_UP: begin
                if (!i_pwr_on_req) begin
                    reload_s = 1'b1;
                end else if (up_done_s) begin
                    reload_s = (idx_r != IDX_LAST);
                end else begin
                    stall_s = cnt_zero_s;
                end
            end
            ON: begin
                reload_s = ~i_pwr_on_req;
            end
            RAMP_DN: begin
                if (i_pwr_on_req) begin
                    reload_s = 1'b1;
                end else if (dn_done_s) begin
                    reload_s = (idx_r != IDX_FIRST);
                end else begin
                    stall_s = cnt_zero_s;
                end
            end
            default: begin
                reload_s = 1'b0;
                stall_s  = 1'b0;
            end
        endcase
    end

    psw_step_timer #(
        .DLY_W  (DLY_W),
        .TO_CYC (TO_CYC)
    ) u_step_timer (
        .i_aon_clk        (i_aon_clk),
        .i_soc_pwr_on_rst (i_soc_pwr_on_rst),
        .reload           (reload_s),
        .reload_val       (i_seg_dly),
        .stall            (stall_s),
        .cnt_zero         (cnt_zero_s),
        .psw_err          (psw_err_s)
    );

    // Sequencer FSM; a request change outranks step completion so reversal is immediate
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            state_r      <= OFF;
            idx_r        <= IDX_FIRST;
            seg_en_r     <= {N_SEG{1'b0}};
            pwr_on_ack_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                OFF: begin
                    if (i_pwr_on_req) begin
                        state_r     <= RAMP_UP;
                        idx_r       <= IDX_FIRST;
                        seg_en_r[0] <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (!i_pwr_on_req) begin
                        state_r         <= RAMP_DN;
                        seg_en_r[idx_r] <= 1'b0;
                    end else if (up_done_s) begin
                        if (idx_r != IDX_LAST) begin
                            idx_r               <= idx_inc_s;
                            seg_en_r[idx_inc_s] <= 1'b1;
                        end else begin
                            state_r      <= ON;
                            pwr_on_ack_r <= 1'b1;
                            busy_r       <= 1'b0;
                        end
                    end
                end
                ON: begin
                    // Segments are deliberately not re-checked while fully on
                    if (!i_pwr_on_req) begin
                        state_r            <= RAMP_DN;
                        idx_r              <= IDX_LAST;
                        seg_en_r[IDX_LAST] <= 1'b0;
                        pwr_on_ack_r       <= 1'b0;
                        busy_r             <= 1'b1;
                    end
                end
                RAMP_DN: begin
                    if (i_pwr_on_req) begin
                        state_r         <= RAMP_UP;
                        seg_en_r[idx_r] <= 1'b1;
                    end else if (dn_done_s) begin
                        if (idx_r != IDX_FIRST) begin
                            idx_r               <= idx_dec_s;
                            seg_en_r[idx_dec_s] <= 1'b0;
                        end else begin
                            state_r <= OFF;
                            busy_r  <= psw_is_ramp(OFF);
                        end
                    end
                end
                default: begin
                    state_r      <= OFF;
                    idx_r        <= IDX_FIRST;
                    seg_en_r     <= {N_SEG{1'b0}};
                    pwr_on_ack_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign o_seg_en     = seg_en_r;
    assign o_pwr_on_ack = pwr_on_ack_r;
    assign o_busy       = busy_r;
    assign o_psw_err    = psw_err_s;

endmodule

// File: tb/tb_pwr_switch_seq.sv
// Self-checking bench for pwr_switch_seq: directed ramps, reversals, slow ack and random req/delay traffic
// checked against a closed-form segment-count model. Watchdog checks run when PSW_TIMEOUT_EN is defined.
module tb_pwr_switch_seq;

    localparam int N_SEG  = 4;
    localparam int DLY_W  = 8;
    localparam int TO_CYC = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic [DLY_W-1:0] dly;
    logic [N_SEG-1:0] ack_block;
    logic [N_SEG-1:0] seg_ack;
    logic [N_SEG-1:0] seg_en;
    logic             pwr_ack;
    logic             busy;
    logic             err;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: direction of the latest phase, edges since it began, segments on at its start, its delay
    int m_dir;
    int m_t;
    int m_c;
    int m_d;
    bit m_err;

    assign seg_ack = seg_en & ~ack_block;

    always #5 clk = ~clk;

    pwr_switch_seq #(
        .N_SEG  (N_SEG),
        .DLY_W  (DLY_W),
        .TO_CYC (TO_CYC)
    ) dut (
        .i_aon_clk        (clk),
        .i_soc_pwr_on_rst (rst),
        .i_pwr_on_req     (req),
        .i_seg_dly        (dly),
        .i_seg_ack        (seg_ack),
        .o_seg_en         (seg_en),
        .o_pwr_on_ack     (pwr_ack),
        .o_busy           (busy),
        .o_psw_err        (err)
    );

    function automatic int exp_cnt();
        int s;
        int c;
        s = (m_t - 1) / (m_d + 1);
        if (m_dir == 1) begin
            c = m_c + 1 + s;
            if (c > N_SEG) c = N_SEG;
        end else begin
            c = m_c - 1 - s;
            if (c < 0) c = 0;
        end
        return c;
    endfunction

    function automatic bit exp_done();
        if (m_dir == 1) return m_t >= (N_SEG - m_c) * (m_d + 1) + 1;
        return m_t >= m_c * (m_d + 1) + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the sampled inputs, then compare at the falling edge
    task automatic tick(input bit use_model);
        int ec;
        bit dn;
        @(posedge clk);
        if (rst) begin
            m_dir = 0; m_t = 1; m_c = 0; m_d = 0; m_err = 1'b0;
        end else if (int'(req) != m_dir) begin
            m_c   = exp_cnt();
            m_dir = int'(req);
            m_t   = 1;
            m_d   = int'(dly);
        end else if (m_t < 100000) begin
            m_t++;
        end
        @(negedge clk);
        if (use_model) begin
            ec = exp_cnt();
            dn = exp_done();
            check("seg_en", 32'(seg_en), 32'((1 << ec) - 1));
            check("pwr_on_ack", 32'(pwr_ack), 32'((m_dir == 1) && dn));
            check("busy", 32'(busy), 32'(!dn));
            check("psw_err", 32'(err), 32'(m_err));
        end
    endtask

    task automatic wait_ack(input string tag);
        int k;
        k = 0;
        while (!pwr_ack && k < 40) begin
            tick(0);
            k++;
        end
        check(tag, 32'(pwr_ack), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req = 1'b0; dly = '0; ack_block = '0;
        m_dir = 0; m_t = 1; m_c = 0; m_d = 0; m_err = 1'b0;

        // Reset state, then idle with req low
        tick(1);
        rst = 1'b0;
        repeat (20) tick(1);

        // Power-up with D=3: one segment every 4 edges, ack at edge 17
        dly = 8'd3; req = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            tick(1);
            if (e == 5)  check("up_e5_en", 32'(seg_en), 32'h3);
            if (e == 16) check("up_e16_ack", 32'(pwr_ack), 32'd0);
            if (e == 17) check("up_e17_ack", 32'(pwr_ack), 32'd1);
        end
        repeat (3) tick(1);

        // Power-down with D=0: one segment per cycle
        dly = 8'd0; req = 1'b0;
        tick(1);
        check("dn_first_en", 32'(seg_en), 32'h7);
        repeat (5) tick(1);
        check("dn_off_en", 32'(seg_en), 32'h0);

        // Reversal mid-up, then re-raise mid-down
        dly = 8'd1; req = 1'b1;
        repeat (3) tick(1);
        check("rev_up_en", 32'(seg_en), 32'h3);
        req = 1'b0;
        tick(1);
        check("rev_dn_en", 32'(seg_en), 32'h1);
        repeat (2) tick(1);
        check("rev_dn_zero", 32'(seg_en), 32'h0);
        req = 1'b1;
        tick(1);
        check("rev_resume_en", 32'(seg_en), 32'h1);
        repeat (12) tick(1);
        check("rev_resume_ack", 32'(pwr_ack), 32'd1);

        // Randomized request toggles with random delays and dwell times
        for (int i = 0; i < 40; i++) begin
            int d;
            int n;
            d = int'($urandom_range(0, 4));
            n = int'($urandom_range(1, N_SEG * (d + 1) + 3));
            dly = DLY_W'(d);
            req = ~req;
            repeat (n) tick(1);
        end
        req = 1'b0;
        repeat (30) tick(1);

        // Reset mid-ramp drops every enable
        dly = 8'd2; req = 1'b1;
        repeat (7) tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; req = 1'b0;
        repeat (3) tick(1);

        // Slow ack on segment 2: ramp holds at 0111 until released
        dly = 8'd1; ack_block = 4'b0100; req = 1'b1;
        repeat (5) tick(0);
        check("slow_en_reach", 32'(seg_en), 32'h7);
        repeat (50) tick(0);
        check("slow_en_hold", 32'(seg_en), 32'h7);
        check("slow_busy", 32'(busy), 32'd1);
        ack_block = '0;
        wait_ack("slow_release_ack");
        check("slow_en_full", 32'(seg_en), 32'hF);
`ifdef PSW_TIMEOUT_EN
        check("slow_err", 32'(err), 32'd1);
`else
        check("slow_err", 32'(err), 32'd0);
`endif
        rst = 1'b1; req = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);

`ifdef PSW_TIMEOUT_EN
        // Watchdog: segment 1 stalls from edge 3, error rises on the 16th stalled edge
        dly = 8'd0; ack_block = 4'b0010; req = 1'b1;
        repeat (17) tick(0);
        check("wd_err_before", 32'(err), 32'd0);
        tick(0);
        check("wd_err_set", 32'(err), 32'd1);
        repeat (10) tick(0);
        check("wd_err_sticky", 32'(err), 32'd1);
        check("wd_en_hold", 32'(seg_en), 32'h3);
        ack_block = '0;
        wait_ack("wd_release_ack");
        check("wd_err_after", 32'(err), 32'd1);
        rst = 1'b1; req = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
